// File: rtl/step_button_conditioner.sv
// Board-input conditioner for the single-step processor: synchronises and debounces the
// step button, display-select button and top-half switch, then derives the step clock/pulse/count.
module step_button_conditioner #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned HOLD_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PushButton,
  input  logic       DisplayTogBtn,
  input  logic       TopHalfSw,
  output logic       step_clk,
  output logic       step_pulse,
  output logic [7:0] step_count,
  output logic       DisplayTog,
  output logic       TopHalf
);

  localparam logic [23:0] DbLast   = 24'(DB_CYCLES - 1);
  localparam logic [23:0] HoldLast = 24'(HOLD_CYCLES - 1);

  // Bit 0: step button, bit 1: display button, bit 2: top-half switch.
  logic [2:0] rawIn;
  logic [2:0] stableVec;

  assign rawIn = {TopHalfSw, DisplayTogBtn, PushButton};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gDebounce
      logic        syncA;
      logic        syncB;
      logic        stableBit;
      logic [23:0] dbCnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          syncA     <= 1'b0;
          syncB     <= 1'b0;
          stableBit <= 1'b0;
          dbCnt     <= '0;
        end else begin
          syncA <= rawIn[gi];
          syncB <= syncA;
          // Any sample agreeing with the stable value restarts the count.
          if (syncB != stableBit) begin
            if (dbCnt == DbLast) begin
              stableBit <= ~stableBit;
              dbCnt     <= '0;
            end else begin
              dbCnt <= dbCnt + 24'd1;
            end
          end else begin
            dbCnt <= '0;
          end
        end
      end

      assign stableVec[gi] = stableBit;
    end
  endgenerate

  logic sb;
  logic dispPrev;

  assign sb      = stableVec[0];
  assign TopHalf = stableVec[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispPrev   <= 1'b0;
      DisplayTog <= 1'b0;
    end else begin
      dispPrev <= stableVec[1];
      if (stableVec[1] && !dispPrev) begin
        DisplayTog <= ~DisplayTog;
      end
    end
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    WAIT_REL = 2'd2
  } stepState_t;

  stepState_t  stateReg;
  stepState_t  stateNext;
  logic [23:0] holdCnt;
  logic [23:0] holdNext;
  logic [7:0]  countNext;
  logic        pulseNext;
  logic        clkNext;

  always_comb begin
    stateNext = stateReg;
    holdNext  = holdCnt;
    countNext = step_count;
    pulseNext = 1'b0;
    case (stateReg)
      IDLE: begin
        if (sb) begin
          stateNext = HIGH;
          holdNext  = '0;
          pulseNext = 1'b1;
          countNext = step_count + 8'd1;
        end
      end
      HIGH: begin
        if (holdCnt == HoldLast) begin
          stateNext = WAIT_REL;
        end else begin
          holdNext = holdCnt + 24'd1;
        end
      end
      WAIT_REL: begin
        // Holding the button forever yields one step; it must be released first.
        if (!sb) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    clkNext = (stateNext == HIGH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= IDLE;
      holdCnt    <= '0;
      step_count <= '0;
      step_pulse <= 1'b0;
      step_clk   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      holdCnt    <= holdNext;
      step_count <= countNext;
      step_pulse <= pulseNext;
      step_clk   <= clkNext;
    end
  end

endmodule

// File: tb/tb_step_button_conditioner.sv
// Randomised and directed checks of step_button_conditioner against a cycle-level
// behavioural model of debounce, toggle and one-step-per-press rules.
module tb_step_button_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       PushButton = 1'b0;
  logic       DisplayTogBtn = 1'b0;
  logic       TopHalfSw = 1'b0;
  logic       step_clk;
  logic       step_pulse;
  logic [7:0] step_count;
  logic       DisplayTog;
  logic       TopHalf;

  int checks = 0;
  int errors = 0;

  step_button_conditioner #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .PushButton(PushButton), .DisplayTogBtn(DisplayTogBtn),
    .TopHalfSw(TopHalfSw), .step_clk(step_clk), .step_pulse(step_pulse),
    .step_count(step_count), .DisplayTog(DisplayTog), .TopHalf(TopHalf)
  );

  always #5 clk = ~clk;

  // Model state: raw samples seen at the last two edges, debounced values, run lengths.
  bit d1[3], d2[3], st[3];
  int run[3];
  bit prevDisp, mDisp, needRel, mPulse;
  int holdLeft, mCount;

  task automatic modelClear();
    for (int i = 0; i < 3; i++) begin
      d1[i] = 0; d2[i] = 0; st[i] = 0; run[i] = 0;
    end
    prevDisp = 0; mDisp = 0; needRel = 0; mPulse = 0; holdLeft = 0; mCount = 0;
  endtask

  task automatic modelEdge();
    bit stOld[3];
    bit raw[3];
    bit seen;
    if (!reset) begin
      modelClear();
      return;
    end
    raw = '{PushButton, DisplayTogBtn, TopHalfSw};
    stOld = st;
    for (int i = 0; i < 3; i++) begin
      seen = d2[i]; d2[i] = d1[i]; d1[i] = raw[i];
      if (seen != st[i]) begin
        if (run[i] == DB - 1) begin st[i] = !st[i]; run[i] = 0; end
        else run[i]++;
      end else run[i] = 0;
    end
    if (stOld[1] && !prevDisp) mDisp = !mDisp;
    prevDisp = stOld[1];
    mPulse = 0;
    if (holdLeft > 0) holdLeft--;
    else if (needRel) begin
      if (!stOld[0]) needRel = 0;
    end else if (stOld[0]) begin
      holdLeft = HOLD; mPulse = 1; mCount = (mCount + 1) % 256; needRel = 1;
    end
  endtask

  function automatic logic [11:0] expVec();
    logic [7:0] c;
    c = 8'(mCount);
    return {(holdLeft > 0), mPulse, c, mDisp, st[2]};
  endfunction

  function automatic logic [11:0] dutVec();
    return {step_clk, step_pulse, step_count, DisplayTog, TopHalf};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic doReset();
    PushButton = 0; DisplayTogBtn = 0; TopHalfSw = 0;
    reset = 0;
    modelClear();
    tick(); tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    modelClear();
    for (int c = 0; c < 5; c++) begin
      PushButton = 1'($urandom); DisplayTogBtn = 1'($urandom); TopHalfSw = 1'($urandom);
      tick();
      checks++;
      if (dutVec() !== 12'h000) begin
        errors++; $display("FAIL reset_hold cyc%0d: got %h want 000", c, dutVec());
      end
    end
    PushButton = 0; DisplayTogBtn = 0; TopHalfSw = 0;
    reset = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dutVec() !== 12'h000 || dutVec() !== expVec()) begin
        errors++; $display("FAIL reset_release cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
    end
  endtask

  task automatic test_glitch();
    doReset();
    PushButton = 1;
    for (int c = 0; c < 18; c++) begin
      if (c == 3) PushButton = 0;
      tick();
      checks++;
      if (dutVec() !== expVec() || step_clk !== 1'b0 || step_pulse !== 1'b0 || step_count !== 8'd0) begin
        errors++; $display("FAIL step_glitch cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
    end
  endtask

  task automatic test_held();
    int pulses, pulseAt, highs, firstHigh;
    doReset();
    PushButton = 1;
    pulses = 0; pulseAt = -1; highs = 0; firstHigh = -1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("FAIL held_model cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
      if (step_pulse === 1'b1) begin pulses++; pulseAt = c; end
      if (step_clk === 1'b1) begin highs++; if (firstHigh < 0) firstHigh = c; end
    end
    checks++;
    if (pulses != 1 || pulseAt != 6 || highs != 3 || firstHigh != 6 || step_count !== 8'd1) begin
      errors++;
      $display("FAIL held_timing: got pulses=%0d at %0d highs=%0d from %0d count=%0d want 1 at 6, 3 from 6, count 1",
               pulses, pulseAt, highs, firstHigh, step_count);
    end
    PushButton = 0;
    for (int c = 0; c < 7; c++) tick();
    PushButton = 1;
    pulseAt = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("FAIL repress_model cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
      if (step_pulse === 1'b1) pulseAt = c;
    end
    checks++;
    if (pulseAt != 6 || step_count !== 8'd2) begin
      errors++; $display("FAIL repress_timing: got pulse at %0d count %0d want 6 and 2", pulseAt, step_count);
    end
  endtask

  task automatic test_presses();
    int highs;
    int batch[2] = '{10, 260};
    int want;
    for (int b = 0; b < 2; b++) begin
      doReset();
      for (int p = 0; p < batch[b]; p++) begin
        highs = 0;
        for (int c = 0; c < 20; c++) begin
          PushButton = (c < 10);
          tick();
          checks++;
          if (dutVec() !== expVec()) begin
            errors++; $display("FAIL press_model b%0d p%0d cyc%0d: got %h want %h", b, p, c, dutVec(), expVec());
          end
          if (step_clk === 1'b1) highs++;
        end
        checks++;
        if (highs != HOLD) begin
          errors++; $display("FAIL press_high b%0d p%0d: got %0d high cycles want %0d", b, p, highs, HOLD);
        end
      end
      want = batch[b] % 256;
      checks++;
      if (step_count !== 8'(want)) begin
        errors++; $display("FAIL press_count b%0d: got %0d want %0d", b, step_count, want);
      end
    end
  endtask

  task automatic test_display_switch();
    logic prev;
    int changeAt;
    logic wantTog[3] = '{1'b1, 1'b0, 1'b1};
    doReset();
    for (int p = 0; p < 3; p++) begin
      DisplayTogBtn = 1;
      prev = DisplayTog; changeAt = -1;
      for (int c = 0; c < 16; c++) begin
        if (c == 8) DisplayTogBtn = 0;
        tick();
        checks++;
        if (dutVec() !== expVec()) begin
          errors++; $display("FAIL disp_model p%0d cyc%0d: got %h want %h", p, c, dutVec(), expVec());
        end
        if (DisplayTog !== prev) begin
          if (changeAt < 0) changeAt = c; else changeAt = 99;
          prev = DisplayTog;
        end
      end
      checks++;
      if (changeAt != 6 || DisplayTog !== wantTog[p]) begin
        errors++; $display("FAIL disp_toggle p%0d: got change at %0d value %b want 6 and %b", p, changeAt, DisplayTog, wantTog[p]);
      end
    end
    TopHalfSw = 1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) TopHalfSw = 0;
      tick();
      checks++;
      if (TopHalf !== 1'b0 || dutVec() !== expVec()) begin
        errors++; $display("FAIL sw_glitch cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
    end
    TopHalfSw = 1;
    changeAt = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("FAIL sw_model cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
      if (TopHalf === 1'b1 && changeAt < 0) changeAt = c;
    end
    checks++;
    if (changeAt != 5) begin
      errors++; $display("FAIL sw_latency: got change at %0d want 5", changeAt);
    end
  endtask

  task automatic test_reset_mid_high();
    int found, pulseAt;
    doReset();
    PushButton = 1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (step_clk === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL midhigh_start: got no step_clk within 20 cycles want high");
    end
    tick();
    #2 reset = 0;
    modelClear();
    #1;
    checks++;
    if (dutVec() !== 12'h000) begin
      errors++; $display("FAIL midhigh_async: got %h want 000", dutVec());
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (dutVec() !== 12'h000) begin
        errors++; $display("FAIL midhigh_hold cyc%0d: got %h want 000", c, dutVec());
      end
    end
    reset = 1;
    pulseAt = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("FAIL midhigh_model cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
      if (step_pulse === 1'b1 && pulseAt < 0) pulseAt = c;
    end
    checks++;
    if (pulseAt != 6 || step_count !== 8'd1) begin
      errors++; $display("FAIL midhigh_restart: got pulse at %0d count %0d want 6 and 1", pulseAt, step_count);
    end
  endtask

  task automatic test_random();
    int left[3];
    doReset();
    for (int i = 0; i < 3; i++) left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (left[i] == 0) begin
          left[i] = int'($urandom_range(1, 12));
          case (i)
            0: PushButton = 1'($urandom);
            1: DisplayTogBtn = 1'($urandom);
            default: TopHalfSw = 1'($urandom);
          endcase
        end
        left[i]--;
      end
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", c, dutVec(), expVec());
      end
    end
  endtask

  initial begin
    modelClear();
    test_reset();
    test_glitch();
    test_held();
    test_presses();
    test_display_switch();
    test_reset_mid_high();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
